// File: rtl/kmp_search_ctrl.sv
// kmp_search_ctrl: sequencer for the string-search datapath.
// It loads the pattern from a small ROM and builds the KMP prefix (LPS) table.
// It then scans the text ROM once, counting overlapping pattern occurrences.
// A mismatch falls back through the LPS table, so a text character is never fetched twice.
module kmp_search_ctrl #(
    parameter int TEXT_LEN = 11064,
    parameter int PAT_LEN  = 4,
    parameter int TXT_AW   = 14,
    parameter int PAT_AW   = 3,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PAT_AW-1:0] pat_addr,
    input  logic [DATA_W-1:0] pat_data,
    output logic [TXT_AW-1:0] txt_addr,
    input  logic [DATA_W-1:0] txt_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  instances,
    output logic [3:0]        state_dbg
);

    // Storage is sized for the largest legal pattern, so every index is exactly 3 bits wide.
    localparam int MAX_PAT = 8;
    localparam logic [2:0]        LAST_IDX  = 3'(PAT_LEN - 1);
    localparam logic [3:0]        LOAD_END  = 4'(PAT_LEN);
    localparam logic [TXT_AW-1:0] LAST_ADDR = TXT_AW'(TEXT_LEN - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        LPS    = 4'd2,
        S_ADDR = 4'd3,
        S_CMP  = 4'd4,
        DONE   = 4'd5
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] pat_reg [MAX_PAT];
    logic [2:0]        lps     [MAX_PAT];
    logic [3:0]        ld_cnt;
    logic [2:0]        i_idx;
    logic [2:0]        len;
    logic [2:0]        j;

    logic [2:0] cap_idx;
    logic       lps_eq;
    logic       lps_done;
    logic       cmp_match;
    logic       at_last_addr;
    logic       advance;

    assign cap_idx      = ld_cnt[2:0] - 3'd1;
    assign lps_eq       = (pat_reg[i_idx] == pat_reg[len]);
    assign lps_done     = (i_idx == LAST_IDX) && (lps_eq || (len == 3'd0));
    assign cmp_match    = (txt_data == pat_reg[j]);
    assign at_last_addr = (txt_addr == LAST_ADDR);
    assign advance      = cmp_match || (j == 3'd0);

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state selection; an unused encoding returns to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE, DONE: state_next = start ? LOAD : state;
            LOAD: begin
                if (ld_cnt == LOAD_END) state_next = (PAT_LEN == 1) ? S_ADDR : LPS;
                else                    state_next = LOAD;
            end
            LPS:    state_next = lps_done ? S_ADDR : LPS;
            S_ADDR: state_next = S_CMP;
            S_CMP: begin
                if (!advance)          state_next = S_CMP;
                else if (at_last_addr) state_next = DONE;
                else                   state_next = S_ADDR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: pattern capture, LPS construction, text scan and the saturating counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_addr  <= '0;
            txt_addr  <= '0;
            instances <= '0;
            ld_cnt    <= '0;
            i_idx     <= '0;
            len       <= '0;
            j         <= '0;
            for (int k = 0; k < MAX_PAT; k++) begin
                pat_reg[k] <= '0;
                lps[k]     <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pat_addr  <= '0;
                        txt_addr  <= '0;
                        instances <= '0;
                        ld_cnt    <= '0;
                        j         <= '0;
                    end
                end
                LOAD: begin
                    pat_addr <= pat_addr + 1'b1;
                    ld_cnt   <= ld_cnt + 4'd1;
                    if (ld_cnt != 4'd0) pat_reg[cap_idx] <= pat_data;
                    if (ld_cnt == LOAD_END) begin
                        i_idx    <= 3'd1;
                        len      <= 3'd0;
                        lps[0]   <= 3'd0;
                        j        <= 3'd0;
                        txt_addr <= '0;
                    end
                end
                LPS: begin
                    if (lps_eq) begin
                        len        <= len + 3'd1;
                        lps[i_idx] <= len + 3'd1;
                        i_idx      <= i_idx + 3'd1;
                    end else if (len != 3'd0) begin
                        len <= lps[len - 3'd1];
                    end else begin
                        lps[i_idx] <= 3'd0;
                        i_idx      <= i_idx + 3'd1;
                    end
                    if (lps_done) begin
                        j        <= 3'd0;
                        txt_addr <= '0;
                    end
                end
                S_CMP: begin
                    if (cmp_match) begin
                        if (j == LAST_IDX) begin
                            if (instances != {CNT_W{1'b1}}) instances <= instances + 1'b1;
                            j <= lps[LAST_IDX];
                        end else begin
                            j <= j + 3'd1;
                        end
                        if (!at_last_addr) txt_addr <= txt_addr + 1'b1;
                    end else if (j != 3'd0) begin
                        j <= lps[j - 3'd1];
                    end else if (!at_last_addr) begin
                        txt_addr <= txt_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
